// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial packed-BCD add/subtract sequencer around one shared BCD digit adder

// dec_adder: one-digit BCD adder with carry in/out
module dec_adder (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] t;
   // binary sum, then +6 correction when the digit overflows past 9
   always_comb begin
      t  = {1'b0, x} + {1'b0, y} + {4'b0, ci};
      co = t > 5'd9;
      s  = co ? 4'(t + 5'd6) : t[3:0];
   end
endmodule

module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                op_sub,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                neg,
   output logic                err,
   output logic                busy,
   output logic                done
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;
   state_t              state, state_n;
   logic [IW-1:0]       idx, idx_n;
   logic                carry, carry_n, sub_q, sub_n;
   logic [4*DIGITS-1:0] a_q, a_n, b_q, b_n, sum_n;
   logic                cout_n, neg_n, err_n, bad, last;
   logic [3:0]          a_d, b_d, s_d, x, y, s;
   logic                co;

   dec_adder u_add (.x(x), .y(y), .ci(carry), .s(s), .co(co));

   // operand muxing for the shared adder: ADD uses A with B or 9-B, FIX negates the stored sum
   always_comb begin
      a_d  = a_q[4*idx +: 4];
      b_d  = b_q[4*idx +: 4];
      s_d  = sum[4*idx +: 4];
      last = idx == IW'(DIGITS - 1);
      x    = state == FIX ? 4'd0 : a_d;
      y    = state == FIX ? 4'd9 - s_d : (sub_q ? 4'd9 - b_d : b_d);
      bad  = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         bad = bad | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
   end

   // next-state and next datapath values
   always_comb begin
      state_n = state;
      idx_n   = idx;
      carry_n = carry;
      sub_n   = sub_q;
      a_n     = a_q;
      b_n     = b_q;
      sum_n   = sum;
      cout_n  = cout;
      neg_n   = neg;
      err_n   = err;
      case (state)
         IDLE: if (start) begin
            a_n   = a;
            b_n   = b;
            sub_n = op_sub;
            neg_n = 1'b0;
            if (bad) begin
               err_n   = 1'b1;
               sum_n   = '0;
               cout_n  = 1'b0;
               state_n = DONE;
            end else begin
               err_n   = 1'b0;
               carry_n = op_sub;
               idx_n   = '0;
               state_n = ADD;
            end
         end
         ADD: begin
            sum_n[4*idx +: 4] = s;
            carry_n = co;
            idx_n   = idx + IW'(1);
            if (last) begin
               cout_n  = co;
               idx_n   = '0;
               state_n = DONE;
               if (sub_q && !co) begin
                  carry_n = 1'b1;
                  neg_n   = 1'b1;
                  state_n = FIX;
               end
            end
         end
         FIX: begin
            sum_n[4*idx +: 4] = s;
            carry_n = co;
            idx_n   = last ? '0 : idx + IW'(1);
            state_n = last ? DONE : FIX;
         end
         default: state_n = IDLE;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         sub_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         neg   <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         carry <= carry_n;
         sub_q <= sub_n;
         a_q   <= a_n;
         b_q   <= b_n;
         sum   <= sum_n;
         cout  <= cout_n;
         neg   <= neg_n;
         err   <= err_n;
         busy  <= state_n != IDLE;
         done  <= state_n == DONE;
      end
   end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed vector bench for the serial BCD add/sub sequencer
module tb_bcd_serial_add_ctrl;
   logic        clk = 1'b0;
   logic        rst, start, op_sub;
   logic [15:0] a, b, sum;
   logic        cout, neg, err, busy, done;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        neg;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   bcd_serial_add_ctrl #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
      .sum(sum), .cout(cout), .neg(neg), .err(err), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // called at #1 after an edge while the DUT is idle; returns at #1 after the first idle edge
   task automatic apply(input logic [15:0] ta, input logic [15:0] tb, input logic ts, output int lat);
      a = ta;
      b = tb;
      op_sub = ts;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!done) lat = -1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  lat;
      bit  seen;
      vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5};
      vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
      vecs[2]  = '{16'h0100, 16'h0042, 1'b1, 16'h0058, 1'b1, 1'b0, 1'b0, 5};
      vecs[3]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
      vecs[4]  = '{16'h0042, 16'h0100, 1'b1, 16'h0058, 1'b0, 1'b1, 1'b0, 9};
      vecs[5]  = '{16'h00A1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
      vecs[6]  = '{16'h0500, 16'h0250, 1'b0, 16'h0750, 1'b0, 1'b0, 1'b0, 5};
      vecs[7]  = '{16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 9};
      vecs[8]  = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
      vecs[9]  = '{16'h0123, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
      vecs[10] = '{16'h9999, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 5};
      vecs[11] = '{16'h0001, 16'h9999, 1'b1, 16'h9998, 1'b0, 1'b1, 1'b0, 9};
      rst = 1'b1;
      start = 1'b0;
      op_sub = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset sum", 32'(sum), 32'h0);
      chk("reset flags", {cout, neg, err, busy, done}, 5'b0);
      for (int i = 0; i < 12; i++) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
         chk($sformatf("v%0d sum", i), 32'(sum), 32'(vecs[i].sum));
         chk($sformatf("v%0d cout", i), 32'(cout), 32'(vecs[i].cout));
         chk($sformatf("v%0d neg", i), 32'(neg), 32'(vecs[i].neg));
         chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d idle", i), {busy, done}, 2'b00);
      end
      // start held high through ADD and the DONE cycle must be ignored
      a = 16'h1234;
      b = 16'h5678;
      op_sub = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 a = 16'h1111;
      b = 16'h2222;
      op_sub = 1'b1;
      chk("busy in add", 32'(busy), 32'h1);
      lat = 1;
      while (!done && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("ignore latency", 32'(lat), 32'd5);
      @(posedge clk);
      #1 start = 1'b0;
      chk("ignore busy", {busy, done}, 2'b00);
      chk("ignore sum", 32'(sum), 32'h6912);
      chk("ignore neg", 32'(neg), 32'h0);
      // back-to-back start in the first idle cycle after done
      apply(16'h0042, 16'h0100, 1'b1, lat);
      chk("b2b sum", 32'(sum), 32'h0058);
      chk("b2b neg cout", {neg, cout}, 2'b10);
      chk("b2b latency", 32'(lat), 32'd9);
      // reset in the middle of ADD aborts with cleared outputs and no done
      a = 16'h4321;
      b = 16'h1111;
      op_sub = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort sum", 32'(sum), 32'h0);
      chk("abort flags", {cout, neg, err, busy, done}, 5'b0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1 seen = seen | done | busy;
      end
      chk("abort no done", 32'(seen), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
